// File: rtl/konami_irq_ctrl.sv
// Interrupt request controller: edge-detected, maskable pending flops arbitrated
// by fixed priority onto one active-low CPU IRQ line held until acknowledged.
module konami_irq_ctrl #(
  parameter int NSRC    = 4,
  parameter int IDW     = 2,
  parameter int HOLDOFF = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_i,
  input  logic            en_we,
  input  logic [NSRC-1:0] en_d,
  input  logic            ack_valid,
  input  logic [IDW-1:0]  ack_id,
  output logic            irq_n,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] en_q
);

  localparam int CW = $clog2(HOLDOFF + 2);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  state_t          state_reg;
  logic [CW-1:0]   hold_cnt_reg;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] src_rise;
  logic [NSRC-1:0] ack_hit;
  logic [IDW-1:0]  winner;
  logic            pend_cur;
  logic            ack_match;

  // Ack IDs at or above NSRC never match any bit, so they are ignored outright.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign src_rise[gi] = src_i[gi] & ~src_q[gi];
    assign ack_hit[gi]  = ack_valid & (ack_id == IDW'(gi));
  end

  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending[i]) winner = IDW'(i);
    end
  end

  always_comb begin
    pend_cur = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (irq_id == IDW'(i)) pend_cur = pending[i];
    end
  end

  assign ack_match = ack_valid & (ack_id == irq_id);

  // Enable acts as the clear pin; a fresh edge beats a same-cycle ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '1;
      pending <= '0;
      en_q    <= '0;
    end else begin
      src_q <= src_i;
      if (en_we) en_q <= en_d;
      for (int i = 0; i < NSRC; i++) begin
        if (!en_q[i])         pending[i] <= 1'b0;
        else if (src_rise[i]) pending[i] <= 1'b1;
        else if (ack_hit[i])  pending[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      irq_n        <= 1'b1;
      irq_id       <= '0;
      hold_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|pending) begin
            irq_id    <= winner;
            irq_n     <= 1'b0;
            state_reg <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ack_match) begin
            irq_n <= 1'b1;
            if (HOLDOFF == 0) begin
              state_reg <= IDLE;
            end else begin
              hold_cnt_reg <= CW'(HOLDOFF);
              state_reg    <= HOLD;
            end
          end else if (!pend_cur) begin
            // Source withdrawn by its enable: drop the line, no holdoff.
            irq_n     <= 1'b1;
            state_reg <= IDLE;
          end
        end
        HOLD: begin
          hold_cnt_reg <= hold_cnt_reg - CW'(1);
          if (hold_cnt_reg <= CW'(1)) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/konami_irq_ctrl.md
# konami_irq_ctrl

Interrupt request controller for the Konami CPU board. It edge-detects up to NSRC level interrupt sources (VBLANK, sound-latch, timer, ...) and latches each into a per-source pending flop with set and clear. It arbitrates the pending flops by fixed priority onto a single active-low CPU IRQ line and holds that line until the CPU acknowledges. It replaces the discrete set/clear flip-flop chain with one clocked block in the main CPU clock domain.

## Interface
- NSRC, 4, number of interrupt sources (1..2^IDW)
- IDW, 2, width of source ID fields
- HOLDOFF, 3, idle cycles forced after an acknowledge before the next assertion (0 allowed)
- clk  in  1  main CPU-domain clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- src_i  in  NSRC  level interrupt sources, synchronous to clk
- en_we  in  1  write strobe for enable mask
- en_d  in  NSRC  new enable mask
- ack_valid  in  1  CPU acknowledge strobe, one cycle
- ack_id  in  IDW  source being acknowledged
- irq_n  out  1  active-low IRQ to CPU
- irq_id  out  IDW  source currently presented; frozen while irq_n=0
- pending  out  NSRC  pending flop state
- en_q  out  NSRC  current enable mask

## Operation
- Edge detect: src_q registers src_i each cycle. edge[i] = src_i[i] & ~src_q[i].
- Pending flop i, priority from highest to lowest at each edge:
  - en_q[i]=0: clear. The enable acts as the flop's clear pin and holds it at 0.
  - edge[i]=1: set. A new edge wins over a same-cycle ack, so no edge is lost.
  - ack_valid=1 and ack_id=i: clear.
  - Otherwise hold.
- en_we=1: en_q <= en_d. Newly disabled sources have their pending cleared on the following edge and stay cleared. An edge arriving in the same cycle as en_we uses the old en_q.
- Arbitration: the lowest index with pending[i]=1 wins.
- FSM states:
  - IDLE: if any pending, latch irq_id <= winner, irq_n <= 0, go to ACTIVE.
  - ACTIVE: irq_n=0 and irq_id frozen.
    - ack_valid with ack_id==irq_id: irq_n <= 1, load the holdoff counter with HOLDOFF, go to HOLDOFF (straight to IDLE if HOLDOFF=0).
    - pending[irq_id] falls without a matching ack (source disabled): irq_n <= 1, go to IDLE, no holdoff.
  - HOLDOFF: irq_n=1. Counter decrements each cycle; at 1 go to IDLE. Pending flops keep latching throughout.
- Ack handling outside the matching case:
  - Mismatched ack_id (valid, < NSRC, not irq_id): clears that pending flop only; FSM unaffected.
  - ack_id >= NSRC: ignored entirely.
  - Ack in IDLE or HOLDOFF: clears pending only.
- Reset:
  - Outputs: irq_n=1, irq_id=0, pending=0, en_q=0.
  - src_q resets to all ones, so a source already high at reset release does not generate an edge.
  - State IDLE, holdoff counter 0.
  - Reset mid-ACTIVE drops irq_n the next edge with no ack required.

## Timing
- src_i rising seen at edge k (with en_q=1): pending set after edge k, irq_n low after edge k+1. Latency is 2 clocks from src_i high to irq_n low.
- Ack at edge a: pending cleared and irq_n high after edge a.
- Re-assert timing after ack at edge a:
  - HOLDOFF=H>0: earliest re-assert after edge a+H+1.
  - HOLDOFF=0: earliest re-assert after edge a+1.
- irq_id is stable from the cycle irq_n falls until it rises.
- A higher-priority source arriving during ACTIVE does not preempt. It is presented after the holdoff.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Basic IRQ/ack: en=4'b0001, pulse src_i[0] high at edge 10, ack_id=0 at edge 20, HOLDOFF=3.
  - Required: pending[0]=1 after edge 10; irq_n=0, irq_id=0 after edge 11; irq_n=1 and pending=0 after edge 20; no re-assert.
- Priority and no-preempt: en=4'b1111; src 2 rises at edge 5, src 0 rises at edge 8; ack id 2 at edge 12.
  - Required: irq_id=2 from edge 6; irq_id=0, irq_n=0 after edge 16 (a+H+1).
- Edge vs ack collision: while presenting id 1, ack_id=1 at edge 30 while src_i[1] shows a new rising edge at edge 30.
  - Required: pending[1] remains 1; irq re-asserts with id 1 after edge 34.
- Enable withdraw: presenting id 3, en_we with en_d=4'b0111 at edge 40.
  - Required: pending[3]=0 after edge 41; irq_n=1 after edge 42; no holdoff; later src 3 edges ignored.
- Reset with level high: src_i=4'b0001 held high across reset release, en=1.
  - Required: no pending, irq_n stays 1 until src 0 falls and rises again.
  - Additionally: assert reset while irq_n=0; all outputs at reset values after that edge.
- Illegal/mismatched ack: NSRC=3, ack_id=3 while presenting id 0.
  - Required: no change.
  - Then ack_id=2 with pending[2]=1: pending[2] cleared, irq_n stays 0.
